axil_cmd_master: RTL and testbench

AXI4-Lite initiator that turns single-word commands from on-chip logic into AXI4-Lite write or read transactions and returns the response. It is the originating end of the AXI-Lite links used by the DAC control path, allowing FPGA-side logic, rather than the JTAG master, to drive the same register slaves. It handles one transaction at a time, with a command/response valid-ready interface on the local side.

---
 rtl/axil_cmd_master_if.sv | 40 ++++
 rtl/axil_cmd_master.sv | 131 +++++++++++++
 tb/tb_axil_cmd_master.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/axil_cmd_master_if.sv
// axil_cmd_master_if: local command/response port plus AXI4-Lite master bus
//   cmd_*    command from on-chip logic (valid/ready)
//   rsp_*    response back to on-chip logic (valid/ready)
//   m_axil_* AXI4-Lite channels AW, W, B, AR, R
//   modport master is the initiator side, modport slave the environment side
interface axil_cmd_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic cmd_valid, cmd_ready, cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic [DATA_WIDTH/8-1:0] cmd_wstrb;
  logic rsp_valid, rsp_ready, rsp_timeout;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic [1:0] rsp_resp;
  logic [ADDR_WIDTH-1:0] m_axil_awaddr, m_axil_araddr;
  logic [2:0] m_axil_awprot, m_axil_arprot;
  logic m_axil_awvalid, m_axil_awready, m_axil_wvalid, m_axil_wready;
  logic [DATA_WIDTH-1:0] m_axil_wdata, m_axil_rdata;
  logic [DATA_WIDTH/8-1:0] m_axil_wstrb;
  logic [1:0] m_axil_bresp, m_axil_rresp;
  logic m_axil_bvalid, m_axil_bready, m_axil_arvalid, m_axil_arready, m_axil_rvalid, m_axil_rready;
  modport master (
    input cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
    input m_axil_awready, m_axil_wready, m_axil_bresp, m_axil_bvalid,
    input m_axil_arready, m_axil_rdata, m_axil_rresp, m_axil_rvalid,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_resp, rsp_timeout,
    output m_axil_awaddr, m_axil_awprot, m_axil_awvalid, m_axil_wdata, m_axil_wstrb, m_axil_wvalid,
    output m_axil_bready, m_axil_araddr, m_axil_arprot, m_axil_arvalid, m_axil_rready
  );
  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
    output m_axil_awready, m_axil_wready, m_axil_bresp, m_axil_bvalid,
    output m_axil_arready, m_axil_rdata, m_axil_rresp, m_axil_rvalid,
    input cmd_ready, rsp_valid, rsp_rdata, rsp_resp, rsp_timeout,
    input m_axil_awaddr, m_axil_awprot, m_axil_awvalid, m_axil_wdata, m_axil_wstrb, m_axil_wvalid,
    input m_axil_bready, m_axil_araddr, m_axil_arprot, m_axil_arvalid, m_axil_rready
  );
endinterface

// File: rtl/axil_cmd_master.sv
// axil_cmd_master: one-at-a-time AXI4-Lite initiator driven by local write/read commands
//   aclk/arst  clock, synchronous active-high reset
//   m          axil_cmd_master_if.master (cmd, rsp and AXI4-Lite channels)
//   AXIL_CMD_MASTER_TIMEOUT_EN enables a TIMEOUT-cycle watchdog that aborts a stuck transaction
module axil_cmd_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT = 1024
) (
  input logic aclk,
  input logic arst,
  axil_cmd_master_if.master m
);
  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP} state_t;
  state_t state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH/8-1:0] wstrb_q;
  logic aw_done, w_done, aw_fin, w_fin;
  assign aw_fin = aw_done | (m.m_axil_awvalid & m.m_axil_awready);
  assign w_fin = w_done | (m.m_axil_wvalid & m.m_axil_wready);
  assign m.m_axil_awaddr = addr_q;
  assign m.m_axil_araddr = addr_q;
  assign m.m_axil_wdata = wdata_q;
  assign m.m_axil_wstrb = wstrb_q;
  assign m.m_axil_awprot = 3'b000;
  assign m.m_axil_arprot = 3'b000;
`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
  logic tmo_q, busy, expire;
  assign busy = state inside {WR_REQ, WR_RESP, RD_REQ, RD_DATA};
  assign expire = busy && cnt == CW'(TIMEOUT - 1);
  assign m.rsp_timeout = tmo_q;
`else
  assign m.rsp_timeout = TIMEOUT < 0;
`endif
  always_ff @(posedge aclk) begin
    if (arst) begin
      state <= IDLE;
      m.cmd_ready <= 1'b1;
      m.rsp_valid <= 1'b0;
      m.rsp_rdata <= '0;
      m.rsp_resp <= 2'b00;
      m.m_axil_awvalid <= 1'b0;
      m.m_axil_wvalid <= 1'b0;
      m.m_axil_bready <= 1'b0;
      m.m_axil_arvalid <= 1'b0;
      m.m_axil_rready <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      aw_done <= 1'b0;
      w_done <= 1'b0;
`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
      cnt <= '0;
      tmo_q <= 1'b0;
`endif
    end else begin
`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
      cnt <= busy ? cnt + 1'b1 : '0;
`endif
      case (state)
        IDLE: if (m.cmd_valid) begin
          m.cmd_ready <= 1'b0;
          addr_q <= m.cmd_addr;
          wdata_q <= m.cmd_wdata;
          wstrb_q <= m.cmd_wstrb;
          aw_done <= 1'b0;
          w_done <= 1'b0;
          state <= m.cmd_write ? WR_REQ : RD_REQ;
          m.m_axil_awvalid <= m.cmd_write;
          m.m_axil_wvalid <= m.cmd_write;
          m.m_axil_arvalid <= !m.cmd_write;
        end
        WR_REQ: begin
          aw_done <= aw_fin;
          w_done <= w_fin;
          m.m_axil_awvalid <= !aw_fin;
          m.m_axil_wvalid <= !w_fin;
          if (aw_fin && w_fin) begin
            m.m_axil_bready <= 1'b1;
            state <= WR_RESP;
          end
        end
        WR_RESP: if (m.m_axil_bvalid) begin
          m.m_axil_bready <= 1'b0;
          m.rsp_resp <= m.m_axil_bresp;
          m.rsp_rdata <= '0;
          m.rsp_valid <= 1'b1;
          state <= RSP;
        end
        RD_REQ: if (m.m_axil_arready) begin
          m.m_axil_arvalid <= 1'b0;
          m.m_axil_rready <= 1'b1;
          state <= RD_DATA;
        end
        RD_DATA: if (m.m_axil_rvalid) begin
          m.m_axil_rready <= 1'b0;
          m.rsp_rdata <= m.m_axil_rdata;
          m.rsp_resp <= m.m_axil_rresp;
          m.rsp_valid <= 1'b1;
          state <= RSP;
        end
        RSP: if (m.rsp_ready) begin
          m.rsp_valid <= 1'b0;
          m.cmd_ready <= 1'b1;
`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
          tmo_q <= 1'b0;
`endif
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
      if (expire) begin
        m.m_axil_awvalid <= 1'b0;
        m.m_axil_wvalid <= 1'b0;
        m.m_axil_bready <= 1'b0;
        m.m_axil_arvalid <= 1'b0;
        m.m_axil_rready <= 1'b0;
        m.rsp_valid <= 1'b1;
        m.rsp_resp <= 2'b10;
        m.rsp_rdata <= '0;
        tmo_q <= 1'b1;
        state <= RSP;
      end
`endif
    end
  end
endmodule

// File: tb/tb_axil_cmd_master.sv
// tb_axil_cmd_master: directed scoreboard bench for axil_cmd_master with a latency-configurable AXI-Lite slave
module tb_axil_cmd_master;
  typedef struct packed {logic [31:0] rdata; logic [1:0] resp; logic tmo;} exp_t;
  logic clk = 1'b0;
  logic arst = 1'b1;
  always #5 clk = ~clk;
  axil_cmd_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
  axil_cmd_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(16)) dut (.aclk(clk), .arst(arst), .m(bus));
  int checks = 0, errors = 0, rsp_seen = 0;
  exp_t q[$];
  int aw_lat = 0, w_lat = 0, b_lat = 0, ar_lat = 0, r_lat = 0;
  logic [1:0] b_resp_cfg = 2'b00, r_resp_cfg = 2'b00;
  logic [31:0] r_data_cfg = 32'h0;
  int aw_cnt, w_cnt, ar_cnt, b_wait, r_wait;
  bit aw_got, w_got, ar_got, b_fire, r_fire;
  int aw_beats = 0, w_beats = 0, ar_beats = 0;
  logic [31:0] aw_addr_seen, w_data_seen, ar_addr_seen;
  logic [3:0] w_strb_seen;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // slave model: reacts shortly after each falling edge; a beat is counted when
  // valid and ready are both set up for the coming rising edge
  always @(negedge clk) begin
    #1;
    if (arst) begin
      bus.m_axil_awready = 0; bus.m_axil_wready = 0; bus.m_axil_arready = 0;
      bus.m_axil_bvalid = 0; bus.m_axil_rvalid = 0; bus.m_axil_bresp = 0;
      bus.m_axil_rresp = 0; bus.m_axil_rdata = 0;
      aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_wait = 0; r_wait = 0;
      aw_got = 0; w_got = 0; ar_got = 0; b_fire = 0; r_fire = 0;
    end else begin
      if (b_fire) begin bus.m_axil_bvalid = 0; b_fire = 0; end
      if (r_fire) begin bus.m_axil_rvalid = 0; r_fire = 0; end
      if (aw_got && w_got && !bus.m_axil_bvalid) begin
        if (b_wait >= b_lat) begin
          bus.m_axil_bvalid = 1; bus.m_axil_bresp = b_resp_cfg;
          aw_got = 0; w_got = 0; b_wait = 0;
        end else b_wait++;
      end
      if (ar_got && !bus.m_axil_rvalid) begin
        if (r_wait >= r_lat) begin
          bus.m_axil_rvalid = 1; bus.m_axil_rdata = r_data_cfg; bus.m_axil_rresp = r_resp_cfg;
          ar_got = 0; r_wait = 0;
        end else r_wait++;
      end
      b_fire = bus.m_axil_bvalid && bus.m_axil_bready;
      r_fire = bus.m_axil_rvalid && bus.m_axil_rready;
      aw_cnt = bus.m_axil_awvalid ? aw_cnt + 1 : 0;
      bus.m_axil_awready = bus.m_axil_awvalid && aw_cnt > aw_lat;
      if (bus.m_axil_awvalid && bus.m_axil_awready) begin aw_beats++; aw_addr_seen = bus.m_axil_awaddr; aw_got = 1; end
      w_cnt = bus.m_axil_wvalid ? w_cnt + 1 : 0;
      bus.m_axil_wready = bus.m_axil_wvalid && w_cnt > w_lat;
      if (bus.m_axil_wvalid && bus.m_axil_wready) begin
        w_beats++; w_data_seen = bus.m_axil_wdata; w_strb_seen = bus.m_axil_wstrb; w_got = 1;
      end
      ar_cnt = bus.m_axil_arvalid ? ar_cnt + 1 : 0;
      bus.m_axil_arready = bus.m_axil_arvalid && ar_cnt > ar_lat;
      if (bus.m_axil_arvalid && bus.m_axil_arready) begin ar_beats++; ar_addr_seen = bus.m_axil_araddr; ar_got = 1; end
    end
  end

  // response monitor: compares every accepted response against the scoreboard
  always @(negedge clk) begin
    #1;
    if (!arst && bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
      rsp_seen++;
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_rsp: got resp %0h rdata %0h, required no response", bus.rsp_resp, bus.rsp_rdata);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("rsp_rdata", bus.rsp_rdata, e.rdata);
        check("rsp_resp", bus.rsp_resp, e.resp);
        check("rsp_timeout", bus.rsp_timeout, e.tmo);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // returns at the falling edge of the cycle after acceptance (cycle 1)
  task automatic send(input bit wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input bit exp_on, input exp_t e);
    @(negedge clk);
    bus.cmd_write = wr; bus.cmd_addr = a; bus.cmd_wdata = d; bus.cmd_wstrb = s; bus.cmd_valid = 1;
    for (int n = 0; n < 200 && bus.cmd_ready !== 1'b1; n++) @(negedge clk);
    check("cmd_accept", bus.cmd_ready, 1);
    if (exp_on) q.push_back(e);
    @(negedge clk);
    bus.cmd_valid = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    int aw_hi, w_hi, br_first, exp_rsp;
    bus.cmd_valid = 0; bus.cmd_write = 0; bus.cmd_addr = 0; bus.cmd_wdata = 0; bus.cmd_wstrb = 0;
    bus.rsp_ready = 1;
    cyc(3);
    check("rst_cmd_ready", bus.cmd_ready, 1);
    check("rst_valids", {bus.m_axil_awvalid, bus.m_axil_wvalid, bus.m_axil_arvalid, bus.m_axil_bready, bus.m_axil_rready}, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp", {bus.rsp_rdata, bus.rsp_resp, bus.rsp_timeout}, 0);
    check("rst_addr_data", {bus.m_axil_awaddr, bus.m_axil_wdata}, 0);
    arst = 0;
    // single write, slave always ready
    send(1, 32'h4, 32'hDEADBEEF, 4'hF, 1, '{32'h0, 2'b00, 1'b0});
    check("wr_c1_valids", {bus.m_axil_awvalid, bus.m_axil_wvalid, bus.m_axil_bready}, 3'b110);
    check("wr_c1_awaddr", bus.m_axil_awaddr, 32'h4);
    check("wr_c1_wdata", bus.m_axil_wdata, 32'hDEADBEEF);
    check("wr_c1_wstrb", bus.m_axil_wstrb, 4'hF);
    check("wr_c1_awprot", bus.m_axil_awprot, 0);
    cyc(1);
    check("wr_c2_bready", {bus.m_axil_bready, bus.m_axil_awvalid, bus.m_axil_wvalid}, 3'b100);
    cyc(1);
    check("wr_c3_rsp_valid", bus.rsp_valid, 1);
    cyc(1);
    check("wr_c4_cmd_ready", {bus.cmd_ready, bus.rsp_valid}, 2'b10);
    check("wr_beats", {aw_beats[7:0], w_beats[7:0]}, 16'h0101);
    check("wr_seen", {aw_addr_seen, w_data_seen, w_strb_seen}, {32'h4, 32'hDEADBEEF, 4'hF});
    // single read
    r_data_cfg = 32'h12345678;
    send(0, 32'hC, 32'h0, 4'h0, 1, '{32'h12345678, 2'b00, 1'b0});
    check("rd_c1_arvalid", {bus.m_axil_arvalid, bus.m_axil_rready}, 2'b10);
    check("rd_c1_araddr", bus.m_axil_araddr, 32'hC);
    cyc(1);
    check("rd_c2_rready", {bus.m_axil_arvalid, bus.m_axil_rready}, 2'b01);
    cyc(1);
    check("rd_c3_rsp", {bus.rsp_valid, bus.rsp_rdata, bus.m_axil_rready}, {1'b1, 32'h12345678, 1'b0});
    cyc(1);
    check("rd_c4_cmd_ready", bus.cmd_ready, 1);
    check("rd_beats", ar_beats, 1);
    check("rd_araddr_seen", ar_addr_seen, 32'hC);
    // staggered AW (3 cycles late) and W (5 cycles late)
    aw_lat = 3; w_lat = 5;
    send(1, 32'h8, 32'h0BADF00D, 4'h3, 1, '{32'h0, 2'b00, 1'b0});
    aw_hi = 0; w_hi = 0; br_first = 0;
    for (int c = 1; c <= 12; c++) begin
      if (bus.m_axil_awvalid) aw_hi++;
      if (bus.m_axil_wvalid) w_hi++;
      if (bus.m_axil_bready && br_first == 0) br_first = c;
      if (c == 5) check("stg_c5_aw_low_w_high", {bus.m_axil_awvalid, bus.m_axil_wvalid}, 2'b01);
      if (c < 12) cyc(1);
    end
    check("stg_aw_cycles", aw_hi, 4);
    check("stg_w_cycles", w_hi, 6);
    check("stg_bready_first", br_first, 7);
    check("stg_beats", {aw_beats[7:0], w_beats[7:0]}, 16'h0202);
    check("stg_rsp_count", rsp_seen, 3);
    aw_lat = 0; w_lat = 0;
    // slave error with response backpressure
    b_resp_cfg = 2'b10;
    bus.rsp_ready = 0;
    send(1, 32'h10, 32'h55, 4'h1, 1, '{32'h0, 2'b10, 1'b0});
    cyc(2);
    for (int c = 3; c <= 6; c++) begin
      check("bp_hold", {bus.rsp_valid, bus.rsp_resp, bus.cmd_ready}, 4'b1100);
      cyc(1);
    end
    bus.rsp_ready = 1;
    cyc(1);
    check("bp_release", {bus.rsp_valid, bus.cmd_ready}, 2'b01);
    b_resp_cfg = 2'b00;
    // AW never accepted
    aw_lat = 100000;
`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
    send(1, 32'h20, 32'h1, 4'hF, 1, '{32'h0, 2'b10, 1'b1});
    cyc(15);
    check("tmo_c16_awvalid", bus.m_axil_awvalid, 1);
    cyc(1);
    check("tmo_c17_valids", {bus.m_axil_awvalid, bus.m_axil_wvalid, bus.m_axil_bready}, 0);
    check("tmo_c17_rsp", {bus.rsp_valid, bus.rsp_resp, bus.rsp_timeout}, 4'b1101);
    exp_rsp = 6;
`else
    send(1, 32'h20, 32'h1, 4'hF, 0, '{32'h0, 2'b00, 1'b0});
    cyc(99);
    check("wait_c100_awvalid", bus.m_axil_awvalid, 1);
    check("wait_c100_rsp", {bus.rsp_valid, bus.rsp_timeout}, 0);
    exp_rsp = 5;
`endif
    cyc(1);
    arst = 1;
    cyc(2);
    arst = 0;
    aw_lat = 0;
    // reset while waiting in RD_DATA, then a normal read
    r_lat = 20;
    send(0, 32'h30, 32'h0, 4'h0, 0, '{32'h0, 2'b00, 1'b0});
    cyc(1);
    check("rst_rd_in_rdata", bus.m_axil_rready, 1);
    arst = 1;
    cyc(1);
    check("rst_rd_valids", {bus.m_axil_awvalid, bus.m_axil_wvalid, bus.m_axil_arvalid, bus.m_axil_bready, bus.m_axil_rready}, 0);
    check("rst_rd_ready_rsp", {bus.cmd_ready, bus.rsp_valid}, 2'b10);
    arst = 0;
    r_lat = 0;
    r_data_cfg = 32'hCAFEF00D;
    send(0, 32'h34, 32'h0, 4'h0, 1, '{32'hCAFEF00D, 2'b00, 1'b0});
    cyc(3);
    check("post_rst_cmd_ready", bus.cmd_ready, 1);
    cyc(3);
    check("queue_empty", q.size(), 0);
    check("rsp_count", rsp_seen, exp_rsp);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
